ui_debounce: RTL and testbench



---
 rtl/ui_debounce_pkg.sv | 7 +
 rtl/ui_debounce_bit.sv | 47 ++++
 rtl/ui_debounce.sv | 49 ++++
 tb/tb_ui_debounce.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ui_debounce_pkg.sv
// ui_debounce_pkg: shared timing constants for the input debouncer
package ui_debounce_pkg;
  localparam int DEFAULT_PRESCALE     = 1000;
  localparam int DEFAULT_STABLE_TICKS = 4;
  localparam int SIM_PRESCALE         = 4;
  localparam int SIM_STABLE_TICKS     = 3;
endpackage

// File: rtl/ui_debounce_bit.sv
// ui_debounce_bit: synchroniser, stability counter and edge pulses for one input channel
module ui_debounce_bit
  import ui_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick,
  input  logic din,
  output logic db_out,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // two-flop synchroniser keeps running while disabled so the first enabled sample is fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], din};
  end

  // any agreeing sample restarts the window; a full run of disagreeing ticks flips the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      db_out <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!ena || sync[1] == db_out) cnt <= '0;
      else if (tick && cnt == LAST) begin
        cnt    <= '0;
        db_out <= ~db_out;
        rise   <= ~db_out;
        fall   <= db_out;
      end else if (tick) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ui_debounce.sv
// ui_debounce: per-pin synchronise and debounce with shared sample prescaler and edge pulses
module ui_debounce
  import ui_debounce_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PRESCALE     = DEFAULT_PRESCALE,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt, pnext;

  // wrap the prescaler after PRESCALE-1
  always_comb pnext = (pcnt == PLAST) ? '0 : pcnt + 1'b1;

  // tick is registered so it is high exactly while the count sits at PRESCALE-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= ena ? pnext : '0;
      tick <= ena && (pnext == PLAST);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ui_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .tick  (tick),
      .din   (din[i]),
      .db_out(db_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end
endmodule

// File: tb/tb_ui_debounce.sv
// tb_ui_debounce: directed vector table plus hand sequences for latency, tick and async reset
module tb_ui_debounce;
  import ui_debounce_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] db_out, rise, fall;
  logic       tick;

  int checks = 0;
  int errors = 0;

  ui_debounce #(.WIDTH(8), .PRESCALE(SIM_PRESCALE), .STABLE_TICKS(SIM_STABLE_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din),
    .db_out(db_out), .rise(rise), .fall(fall), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic [7:0] din;
    int         cyc;
    logic [7:0] db;
    logic [7:0] r;
    logic [7:0] f;
    int         pc;
  } vec_t;

  vec_t vec [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int cyc, output logic [7:0] r_acc, output logic [7:0] f_acc,
                     output int pc, output int ovl, output int tc);
    r_acc = '0; f_acc = '0; pc = 0; ovl = 0; tc = 0;
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      r_acc |= rise;
      f_acc |= fall;
      if ((rise | fall) != 0) pc++;
      if ((rise & fall) != 0) ovl++;
      if (tick) tc++;
    end
  endtask

  initial begin
    logic [7:0] ra, fa, r_at;
    int pc, ovl, tc, n;
    bit got, seen;

    vec[0] = '{1'b1, 8'h00, 50, 8'h00, 8'h00, 8'h00, 0};
    vec[1] = '{1'b1, 8'h01, 20, 8'h01, 8'h01, 8'h00, 1};
    vec[2] = '{1'b1, 8'h09,  6, 8'h01, 8'h00, 8'h00, 0};
    vec[3] = '{1'b1, 8'h01, 20, 8'h01, 8'h00, 8'h00, 0};
    vec[4] = '{1'b1, 8'h00, 20, 8'h00, 8'h00, 8'h01, 1};
    vec[5] = '{1'b1, 8'hA5, 20, 8'hA5, 8'hA5, 8'h00, 1};
    vec[6] = '{1'b1, 8'h5A, 20, 8'h5A, 8'h5A, 8'hA5, 1};
    vec[7] = '{1'b1, 8'hFF, 20, 8'hFF, 8'hA5, 8'h00, 1};
    vec[8] = '{1'b0, 8'h00, 40, 8'hFF, 8'h00, 8'h00, 0};

    repeat (3) @(negedge clk);
    chk("rst_db", 32'(db_out), 32'h00);
    chk("rst_rise", 32'(rise), 32'h00);
    chk("rst_fall", 32'(fall), 32'h00);
    chk("rst_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;

    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = tick;
    end
    chk("tick_found", 32'(seen), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("tick_period", 32'(tick), 32'(k % 4 == 0));
    end

    for (int v = 0; v < 9; v++) begin
      ena = vec[v].ena;
      din = vec[v].din;
      run(vec[v].cyc, ra, fa, pc, ovl, tc);
      chk($sformatf("v%0d_db", v), 32'(db_out), 32'(vec[v].db));
      chk($sformatf("v%0d_rise", v), 32'(ra), 32'(vec[v].r));
      chk($sformatf("v%0d_fall", v), 32'(fa), 32'(vec[v].f));
      chk($sformatf("v%0d_pulse_cycles", v), 32'(pc), 32'(vec[v].pc));
      chk($sformatf("v%0d_overlap", v), 32'(ovl), 32'h0);
      if (!vec[v].ena) chk($sformatf("v%0d_tick_off", v), 32'(tc), 32'h0);
    end
    ena = 1'b1;
    din = 8'h00;
    vec[8].ena = 1'b1;
    run(20, ra, fa, pc, ovl, tc);
    chk("reen_db", 32'(db_out), 32'h00);
    chk("reen_fall", 32'(fa), 32'hFF);
    chk("reen_pulse_cycles", 32'(pc), 32'h1);

    din = 8'h01;
    n = 0; got = 0; r_at = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      n++;
      if (db_out[0]) begin
        got = 1;
        r_at = rise;
      end
    end
    chk("lat_window", 32'(n >= 11 && n <= 15), 32'h1);
    chk("lat_rise", 32'(r_at), 32'h01);
    @(negedge clk);
    chk("lat_rise_once", 32'(rise), 32'h00);
    din = 8'h00;
    run(20, ra, fa, pc, ovl, tc);
    chk("lat_back_db", 32'(db_out), 32'h00);

    din = 8'hFF;
    run(20, ra, fa, pc, ovl, tc);
    chk("pre_rst_db", 32'(db_out), 32'hFF);
    din = 8'h00;
    run(9, ra, fa, pc, ovl, tc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_db", 32'(db_out), 32'h00);
    chk("async_rise", 32'(rise), 32'h00);
    chk("async_fall", 32'(fall), 32'h00);
    chk("async_tick", 32'(tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("post_rst_tick", 32'(tick), 32'(k == 3));
    end
    run(20, ra, fa, pc, ovl, tc);
    chk("post_rst_db", 32'(db_out), 32'h00);
    chk("post_rst_pulses", 32'(pc), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
